// File: rtl/vect_relu_argmax_pkg.sv
// Shared types and constants for the ReLU/argmax sweep that follows the
// matrix-vector multiplier.
package vect_relu_argmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
  localparam int          FP32_SIGN_BIT = 31;

  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_IDX_LSB = 16;
  localparam int STAT_IDX_W   = 16;

  // Any negative pattern, including -0, collapses to +0.
  function automatic logic [31:0] fp32_relu(input logic [31:0] v);
    return v[FP32_SIGN_BIT] ? FP32_ZERO : v;
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational float32 strict greater-than on sign-magnitude bit patterns;
// +0 and -0 compare equal, NaN/Inf are treated as ordinary bit patterns.
module fp32_gt
  import vect_relu_argmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  logic        sign_a;
  logic        sign_b;
  logic [30:0] mag_a;
  logic [30:0] mag_b;

  assign sign_a = a[FP32_SIGN_BIT];
  assign sign_b = b[FP32_SIGN_BIT];
  assign mag_a  = a[30:0];
  assign mag_b  = b[30:0];

  always_comb begin
    a_gt_b = 1'b0;
    if ((mag_a == '0) && (mag_b == '0)) begin
      a_gt_b = 1'b0;
    end else if (sign_a != sign_b) begin
      a_gt_b = !sign_a;
    end else if (!sign_a) begin
      a_gt_b = (mag_a > mag_b);
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      a_gt_b = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/vect_relu_argmax.sv
// Sweeps y out of BRAM, writes ReLU(y) into z and tracks argmax/max of y,
// started and acknowledged through the ps_control/pl_status handshake.
module vect_relu_argmax
  import vect_relu_argmax_pkg::*;
#(
  parameter int length_M    = 128,
  parameter int addr_y_size = 12,
  parameter int addr_z_size = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ps_control,
  output logic [31:0]            pl_status,
  output logic [31:0]            max_value,
  output logic [addr_y_size-1:0] bram_addr_y,
  input  logic [31:0]            bram_rddata_y,
  output logic [31:0]            bram_wrdata_y,
  output logic [3:0]             bram_we_y,
  output logic [addr_z_size-1:0] bram_addr_z,
  input  logic [31:0]            bram_rddata_z,
  output logic [31:0]            bram_wrdata_z,
  output logic [3:0]             bram_we_z
);

  localparam int             CW       = $clog2(length_M) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(length_M - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            cnt_inc;
  logic [addr_y_size-1:0]   addr_y_q;
  logic                     valid_q;
  logic [CW-1:0]            idx_pipe_q;
  logic [CW-1:0]            max_idx_q;
  logic [31:0]              max_val_q;
  logic                     y_gt_max;
  logic                     take_max;
  logic                     start;
  logic                     unused_inputs;

  assign start         = ps_control[0];
  assign unused_inputs = ^{bram_rddata_z, ps_control[31:1]};
  assign cnt_inc       = cnt_q + CNT_ONE;

  fp32_gt u_fp32_gt (
    .a      (bram_rddata_y),
    .b      (max_val_q),
    .a_gt_b (y_gt_max)
  );

  // Element 0 seeds the running max; later elements must be strictly greater.
  assign take_max = valid_q && ((idx_pipe_q == '0) || y_gt_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_y_q   <= '0;
      valid_q    <= 1'b0;
      idx_pipe_q <= '0;
      max_idx_q  <= '0;
      max_val_q  <= FP32_ZERO;
    end else begin
      // Read data lags its address by one cycle; the pipeline tags it.
      valid_q    <= (state_q == ST_READ);
      idx_pipe_q <= cnt_q;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_READ;
            cnt_q     <= '0;
            addr_y_q  <= '0;
            max_idx_q <= '0;
            max_val_q <= FP32_ZERO;
          end
        end
        ST_READ: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DRAIN;
          end else begin
            cnt_q    <= cnt_inc;
            addr_y_q <= addr_y_size'({cnt_inc, 2'b00});
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (!start) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (take_max) begin
        max_idx_q <= idx_pipe_q;
        max_val_q <= bram_rddata_y;
      end
    end
  end

  always_comb begin
    pl_status = '0;
    if (state_q != ST_IDLE) begin
      pl_status[STAT_IDX_LSB +: STAT_IDX_W] = STAT_IDX_W'(max_idx_q);
    end
    pl_status[STAT_DONE] = (state_q == ST_DONE);
    pl_status[STAT_BUSY] = (state_q == ST_READ) || (state_q == ST_DRAIN);
  end

  assign max_value     = max_val_q;
  assign bram_addr_y   = addr_y_q;
  assign bram_wrdata_y = '0;
  assign bram_we_y     = '0;

  // z write path is gated by the valid tag so reset silences it at once.
  assign bram_addr_z   = addr_z_size'({idx_pipe_q, 2'b00});
  assign bram_wrdata_z = valid_q ? fp32_relu(bram_rddata_y) : FP32_ZERO;
  assign bram_we_z     = valid_q ? 4'hF : 4'h0;

endmodule

// File: tb/tb_vect_relu_argmax.sv
// Directed bench for vect_relu_argmax with behavioural y/z BRAMs.
module tb_vect_relu_argmax;

  localparam int M = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ps_control = 32'h0;
  logic [31:0] pl_status;
  logic [31:0] max_value;
  logic [11:0] bram_addr_y;
  logic [31:0] bram_rddata_y = 32'h0;
  logic [31:0] bram_wrdata_y;
  logic [3:0]  bram_we_y;
  logic [11:0] bram_addr_z;
  logic [31:0] bram_rddata_z = 32'h0;
  logic [31:0] bram_wrdata_z;
  logic [3:0]  bram_we_z;

  logic [31:0] ymem [M];
  logic [31:0] zmem [M];
  logic [31:0] zexp [M];

  int   wr_cnt    = 0;
  int   ord_err   = 0;
  int   exp_addr  = 0;
  logic sweep_clr = 1'b0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  vect_relu_argmax #(
    .length_M    (M),
    .addr_y_size (12),
    .addr_z_size (12)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps_control    (ps_control),
    .pl_status     (pl_status),
    .max_value     (max_value),
    .bram_addr_y   (bram_addr_y),
    .bram_rddata_y (bram_rddata_y),
    .bram_wrdata_y (bram_wrdata_y),
    .bram_we_y     (bram_we_y),
    .bram_addr_z   (bram_addr_z),
    .bram_rddata_z (bram_rddata_z),
    .bram_wrdata_z (bram_wrdata_z),
    .bram_we_z     (bram_we_z)
  );

  always @(posedge clk) bram_rddata_y <= ymem[bram_addr_y[8:2]];

  // z BRAM: records writes and flags gaps, reorders or partial byte enables.
  always @(posedge clk) begin
    if (sweep_clr) begin
      exp_addr = 0;
      for (int i = 0; i < M; i++) zmem[i] = 32'hDEAD_BEEF;
    end else if (bram_we_z != 4'h0) begin
      if (bram_we_z != 4'hF || bram_addr_z != 12'(exp_addr)) ord_err++;
      zmem[bram_addr_z[8:2]] = bram_wrdata_z;
      wr_cnt++;
      exp_addr += 4;
    end
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] yv, input logic [31:0] zv);
    for (int i = 0; i < M; i++) begin
      ymem[i] = yv;
      zexp[i] = zv;
    end
  endtask

  task automatic run_case(input string tag, input int hold,
                          input logic [15:0] exp_idx, input logic [31:0] exp_max);
    int lat;
    int base_wr;
    int base_ord;
    int bad;
    logic [31:0] first_st;
    logic [31:0] done_st;
    @(negedge clk); sweep_clr = 1'b1;
    @(negedge clk); sweep_clr = 1'b0;
    base_wr  = wr_cnt;
    base_ord = ord_err;
    first_st = '0;
    ps_control = 32'h1;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) first_st = pl_status;
      if (pl_status[0]) break;
    end
    done_st = pl_status;
    repeat (hold) @(posedge clk);
    @(negedge clk); ps_control = 32'h0;
    @(posedge clk); #1;
    check32({tag, "_clear"}, pl_status, 32'h0);
    check32({tag, "_lat"}, 32'(lat), 32'd130);
    check32({tag, "_busy"}, first_st, 32'h0000_0002);
    check32({tag, "_done"}, done_st, {exp_idx, 16'h0001});
    check32({tag, "_writes"}, 32'(wr_cnt - base_wr), 32'd128);
    check32({tag, "_order"}, 32'(ord_err - base_ord), 32'd0);
    bad = 0;
    for (int i = 0; i < M; i++) if (zmem[i] !== zexp[i]) bad++;
    check32({tag, "_zbad"}, 32'(bad), 32'd0);
    check32({tag, "_max"}, max_value, exp_max);
    $display("[TB] sweep %s: lat=%0d idx=%0d max=%h writes=%0d",
             tag, lat, done_st[31:16], max_value, wr_cnt - base_wr);
  endtask

  initial begin
    int base_wr;
    fill(32'h0, 32'h0);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_status", pl_status, 32'h0);
    check32("rst_max", max_value, 32'h0);
    check32("rst_addr_y", 32'(bram_addr_y), 32'h0);
    check32("rst_addr_z", 32'(bram_addr_z), 32'h0);
    check32("rst_wrdata_z", bram_wrdata_z, 32'h0);
    check32("rst_we_z", 32'(bram_we_z), 32'h0);
    @(negedge clk); reset = 1'b0;

    fill(32'h3F80_0000, 32'h3F80_0000);
    run_case("ones", 0, 16'd0, 32'h3F80_0000);

    fill(32'h0, 32'h0);
    ymem[5] = 32'h42C8_0000;  zexp[5] = 32'h42C8_0000;
    ymem[77] = 32'h4278_0000; zexp[77] = 32'h4278_0000;
    run_case("two_peaks", 0, 16'd5, 32'h42C8_0000);
    check32("two_peaks_z5", zmem[5], 32'h42C8_0000);
    check32("two_peaks_z77", zmem[77], 32'h4278_0000);

    fill(32'hC000_0000, 32'h0);
    ymem[9] = 32'hBF80_0000;
    run_case("negative", 0, 16'd9, 32'hBF80_0000);

    fill(32'h0, 32'h0);
    ymem[3] = 32'h4120_0000;   zexp[3] = 32'h4120_0000;
    ymem[100] = 32'h4120_0000; zexp[100] = 32'h4120_0000;
    run_case("tie_hold", 20, 16'd3, 32'h4120_0000);

    fill(32'h0, 32'h0);
    ymem[0] = 32'h8000_0000;
    run_case("neg_zero", 0, 16'd0, 32'h8000_0000);
    check32("neg_zero_z0", zmem[0], 32'h0);

    fill(32'h3F80_0000, 32'h3F80_0000);
    ymem[127] = 32'h4000_0000; zexp[127] = 32'h4000_0000;
    run_case("last_max", 0, 16'd127, 32'h4000_0000);

    // Abort a sweep with reset 40 cycles after start.
    fill(32'h3F80_0000, 32'h3F80_0000);
    @(negedge clk); ps_control = 32'h1;
    repeat (40) @(posedge clk);
    #1;
    check32("abort_busy", pl_status[1:0], 32'h2);
    reset = 1'b1;
    #1;
    check32("abort_status", pl_status, 32'h0);
    check32("abort_max", max_value, 32'h0);
    check32("abort_addr_y", 32'(bram_addr_y), 32'h0);
    check32("abort_addr_z", 32'(bram_addr_z), 32'h0);
    check32("abort_wrdata_z", bram_wrdata_z, 32'h0);
    check32("abort_we_z", 32'(bram_we_z), 32'h0);
    base_wr = wr_cnt;
    ps_control = 32'h0;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check32("abort_no_writes", 32'(wr_cnt - base_wr), 32'd0);
    check32("abort_idle", pl_status, 32'h0);
    $display("[TB] reset abort: writes after reset=%0d", wr_cnt - base_wr);

    run_case("after_reset", 0, 16'd0, 32'h3F80_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vect_relu_argmax.md
# vect_relu_argmax

Downstream stage of `matrixvect_mult`. It sweeps the length-M float32 result vector `y` out of its BRAM and writes ReLU(y[i]) to an output BRAM `z`. In the same pass it tracks the index and value of the largest `y` element. It is started and acknowledged by the PS through the same `ps_control`/`pl_status` handshake the multiplier uses, so the PS can chain multiply → activation/classify without moving data.

## Interface
Parameters:
- `length_M`, 128, number of float32 elements in y/z
- `addr_y_size`, 12, byte-address width of the y BRAM port
- `addr_z_size`, 12, byte-address width of the z BRAM port

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high
- `ps_control`  in  32  bit 0 = start; bits 31:1 ignored
- `pl_status`  out  32  bit 0 = done, bit 1 = busy, bits 31:16 = argmax index, others 0
- `max_value`  out  32  float32 bit pattern of y[argmax]
- `bram_addr_y`  out  addr_y_size  byte address into y
- `bram_rddata_y`  in  32  y read data, 1-cycle registered latency
- `bram_wrdata_y`  out  32  tied 0
- `bram_we_y`  out  4  tied 0
- `bram_addr_z`  out  addr_z_size  byte address into z
- `bram_rddata_z`  in  32  unused
- `bram_wrdata_z`  out  32  ReLU result
- `bram_we_z`  out  4  4'hF on write cycles, else 0

## Operation
- FSM states: IDLE → READ → DRAIN → DONE → IDLE.
- IDLE:
  - `pl_status` = 0; `bram_we_z` = 0.
  - `ps_control[0]` = 1 at an edge → READ.
  - That edge clears the index counter and the argmax state.
- READ: issues `bram_addr_y` = 4·i for i = 0..M-1, one element per cycle. After i = M-1 → DRAIN.
- Processing, for data returning one cycle after its address:
  - z write: `bram_addr_z` = 4·i, `bram_we_z` = 4'hF.
  - Write data is 0x00000000 if the sign bit is set (so −0 also maps to +0); otherwise y[i] unchanged.
  - Argmax: replace (idx, value) only if y[i] is strictly greater than the current max. Ties keep the lower index.
  - Element 0 always initialises the max.
- DRAIN: processes the last element → DONE.
- DONE:
  - `pl_status[0]` = 1.
  - Hold until `ps_control[0]` = 0, then → IDLE.
  - Start held high through DONE does not restart the sweep.
- Float compare, done in the `fp32_gt` sub-module:
  - Sign-magnitude compare; +0 and −0 are equal.
  - Positive operand > negative operand.
  - Both positive: larger magnitude bits win. Both negative: smaller magnitude bits win.
  - NaN/Inf are not expected and are compared as raw bits under the same rules.
- Argmax index is zero-extended into `pl_status[31:16]`.
- `max_value` and the index persist through IDLE until the next start.

## Timing
- Reset (asynchronous) value of every output:
  - `pl_status` = 0, `max_value` = 0.
  - `bram_addr_y` = 0, `bram_addr_z` = 0, `bram_wrdata_z` = 0, `bram_we_z` = 0.
  - State = IDLE.
- Reset mid-sweep aborts immediately: no further z writes and busy drops. z contents already written are left as is.
- Let start be sampled at edge t:
  - Cycle t+1+i: address for element i is driven.
  - Cycle t+2+i: z write for element i is driven.
  - `pl_status[0]` rises in cycle t+M+2.
  - Total latency from start to done is M+2 cycles.
- `pl_status[1]` (busy) is high in READ and DRAIN only.
- After `ps_control[0]` falls at edge u, `pl_status[0]` reads 0 in cycle u+1.
- Exactly M z writes per sweep, with no gaps and no duplicate addresses. Address wrap beyond 4·(M-1) never occurs.

## Structure
- Shared package `vect_relu_argmax_pkg` holds:
  - the state enum;
  - `FP32_ZERO` = 32'h0 and `FP32_SIGN_BIT` = 31;
  - `pl_status` field positions (DONE = 0, BUSY = 1, IDX_LSB = 16).
- One sub-module, `fp32_gt` (purely combinational; inputs a, b; output a_gt_b), so the comparator can be unit-tested in isolation.
- Top module holds the FSM, the index counter (width $clog2(length_M)+1), one-cycle valid/index pipeline register, and argmax registers.

## Test plan
- y all 1.0 (3F800000), M = 128 → z all 3F800000; idx 0; `max_value` 3F800000; done at start+130.
- y[5] = 42C80000 (100.0), y[77] = 42780000 (62.0), rest 0 → idx 5; z[5] = 42C80000, z[77] = 42780000.
- y all negative, y[i] = C0000000 except y[9] = BF800000 (−1.0) → every z = 0; idx 9; `max_value` BF800000.
- Tie: y[3] = y[100] = 41200000, rest 0 → idx 3. Also y[0] = 80000000 (−0), rest 0 → idx 0 and z[0] = 00000000.
- Handshake: hold start high 20 cycles past done → exactly 128 z writes. Drop start → `pl_status` = 0 next cycle. A second start reruns and clears the old max.
- Assert reset at start+40 → all outputs 0 in the same cycle, no z writes afterwards. A new start after reset completes normally.
